// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a multi-cycle multiply / restoring-divide engine.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO via valid/ready; cancel aborts in-flight work.
module hilo_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_read,
  output logic [WIDTH-1:0] lo_read
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] sr;
  logic               mul_signed, q_neg, r_neg, div_zero;
  logic               accept, write_mul, write_div;
  logic               a_neg_in, b_neg_in;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] sr_step;
  logic [WIDTH-1:0]   quot, rem;

  assign hi_read = hi;
  assign lo_read = lo;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    write_mul = 1'b0;
    write_div = 1'b0;
    op_ready  = (state == IDLE) && !cancel;
    busy      = (state != IDLE);
    accept    = op_valid && op_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_nxt = MUL;
            OP_DIV, OP_DIVU:   state_nxt = DIV;
            default:           state_nxt = IDLE;
          endcase
        end
      end
      MUL: begin
        if (cancel) state_nxt = IDLE;
        else if (cnt == '0) begin
          write_mul = resetn;
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (cancel)          state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX: begin
        write_div = !cancel && resetn;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    done = write_mul || write_div;
  end

  // Divide works on magnitudes; signs are reapplied in FIX.
  always_comb begin
    a_neg_in = (op == OP_DIV) && src_a[WIDTH-1];
    b_neg_in = (op == OP_DIV) && src_b[WIDTH-1];
    ext_a    = mul_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    ext_b    = mul_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    product  = ext_a * ext_b;
    rem_sh   = sr[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, b_reg};
    sr_step  = diff[WIDTH] ? {rem_sh[WIDTH-1:0], sr[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0],   sr[WIDTH-2:0], 1'b1};
    quot     = q_neg ? -sr[WIDTH-1:0]       : sr[WIDTH-1:0];
    rem      = r_neg ? -sr[2*WIDTH-1:WIDTH] : sr[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg      <= src_a;
      b_reg      <= b_neg_in ? -src_b : src_b;
      sr         <= {{WIDTH{1'b0}}, (a_neg_in ? -src_a : src_a)};
      mul_signed <= (op == OP_MULT);
      q_neg      <= a_neg_in ^ b_neg_in;
      r_neg      <= a_neg_in;
      div_zero   <= (src_b == '0);
      cnt        <= (op == OP_MULT || op == OP_MULTU) ? CW'(MUL_LAT-1) : CW'(WIDTH-1);
    end else begin
      if (state != IDLE) cnt <= cnt - CW'(1);
      if (state == DIV)  sr  <= sr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept && op == OP_MTHI) hi <= src_a;
      if (accept && op == OP_MTLO) lo <= src_a;
      if (write_mul) {hi, lo} <= product;
      if (write_div) begin
        lo <= div_zero ? '1    : quot;
        hi <= div_zero ? a_reg : rem;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus pushes reference results, a monitor
// pops and compares HI/LO after every done pulse.
module tb_hilo_muldiv;

  localparam int W  = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          resetn, op_valid, cancel;
  logic [2:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          op_ready, busy, done;
  logic [W-1:0]  hi_read, lo_read;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .cancel(cancel), .busy(busy),
    .done(done), .hi_read(hi_read), .lo_read(lo_read)
  );

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } res_t;

  res_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result computed with plain integer arithmetic.
  function automatic res_t ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      p;
    logic [63:0] u;
    int          sa, sbv;
    r.hi = m_hi;
    r.lo = m_lo;
    sa   = $signed(a);
    sbv  = $signed(b);
    case (o)
      3'b000: begin p = longint'(sa) * longint'(sbv); r = res_t'(p); end
      3'b001: begin u = {32'd0, a} * {32'd0, b}; r = res_t'(u); end
      3'b010: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.hi = 32'd0; r.lo = 32'h8000_0000; end
        else begin r.lo = sa / sbv; r.hi = sa % sbv; end
      end
      3'b011: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFF_FFFF; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      3'b100: r.hi = a;
      3'b101: r.lo = a;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: a done pulse means HI/LO hold the next queued result after the edge.
  initial begin
    res_t e;
    forever begin
      @(negedge clk); #2;
      if (done === 1'b1) begin
        check("done_while_busy", busy, 1);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          e = sb.pop_front();
          check("result_hilo", {hi_read, lo_read}, e);
        end
      end
    end
  end

  // cancel_at = k > 0 raises cancel in busy cycle T+k; 0 lets the op complete.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int cancel_at);
    res_t e;
    int   lat, n, guard;
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    guard = 0;
    while (op_ready !== 1'b1 && guard < 100) begin @(negedge clk); #1; guard++; end
    if (guard >= 100) begin
      check("accept_timeout", op_ready, 1);
      op_valid = 1'b0;
      return;
    end
    e = ref_model(o, a, b);
    @(posedge clk); #1;
    op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    if (o <= 3'b011) begin
      lat = o[1] ? W + 1 : ML;
      if (cancel_at >= 1 && cancel_at <= lat) begin
        repeat (cancel_at) @(negedge clk);
        cancel = 1'b1;
        #1;
        check("busy_at_cancel", busy, 1);
        check("done_blocked_by_cancel", done, 0);
        @(negedge clk);
        check("busy_after_cancel", busy, 0);
        cancel = 1'b0;
        #1;
        check("ready_after_cancel", op_ready, 1);
        check("hilo_after_cancel", {hi_read, lo_read}, {m_hi, m_lo});
      end else begin
        sb.push_back(e);
        m_hi = e.hi; m_lo = e.lo;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        check("busy_cycles", n, lat);
      end
    end else begin
      check("no_busy_simple_op", busy, 0);
      check("hilo_simple_op", {hi_read, lo_read}, e);
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  initial begin
    res_t        e;
    int          n_rdy, nb;
    logic [2:0]  o;
    logic [31:0] a, b, hold_data;
    int          ca;

    resetn = 1'b0; op_valid = 1'b0; cancel = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {hi_read, lo_read}, 64'd0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", op_ready, 1);
    resetn = 1'b1;

    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    issue(3'b011, 32'h0000_0064, 32'h0000_0007, 0);
    issue(3'b011, 32'h0000_1234, 32'h0000_0000, 0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'b010, 32'h0000_0000, 32'h0000_0000, 0);
    issue(3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    issue(3'b010, 32'h1234_5678, 32'h0000_0003, 10);
    issue(3'b011, 32'hDEAD_BEEF, 32'h0000_0010, W + 1);
    issue(3'b000, 32'h0000_1111, 32'h0000_2222, ML);

    // MTHI then MTLO on consecutive cycles.
    @(negedge clk);
    op_valid = 1'b1; op = 3'b100; src_a = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    check("mthi_t1", {hi_read, lo_read}, {32'hA5A5_A5A5, m_lo});
    m_hi = 32'hA5A5_A5A5;
    op = 3'b101; src_a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    check("mtlo_t2", {hi_read, lo_read}, {m_hi, 32'h5A5A_5A5A});
    m_lo = 32'h5A5A_5A5A;
    op_valid = 1'b0;

    // op_valid held with a pending MTHI across a whole DIV.
    hold_data = $urandom;
    @(negedge clk);
    op_valid = 1'b1; op = 3'b010; src_a = 32'hFFFF_FF00; src_b = 32'h0000_0007;
    e = ref_model(3'b010, 32'hFFFF_FF00, 32'h0000_0007);
    @(posedge clk); #1;
    sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    op = 3'b100; src_a = hold_data;
    n_rdy = 0; nb = 0;
    @(negedge clk); #1;
    while (busy === 1'b1 && nb < 100) begin
      if (op_ready !== 1'b0) n_rdy++;
      nb++;
      @(negedge clk); #1;
    end
    check("ready_while_busy", n_rdy, 0);
    check("held_div_busy_cycles", nb, W + 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("held_mthi_after_idle", {hi_read, lo_read}, {hold_data, m_lo});
    m_hi = hold_data;

    // cancel in IDLE blocks acceptance.
    @(negedge clk);
    cancel = 1'b1; op_valid = 1'b1; op = 3'b101; src_a = ~m_lo;
    #1;
    check("ready_under_cancel", op_ready, 0);
    @(posedge clk); #1;
    check("hilo_cancel_idle", {hi_read, lo_read}, {m_hi, m_lo});
    cancel = 1'b0; op_valid = 1'b0;

    issue(3'b110, 32'h1111_1111, 32'h2222_2222, 0);
    issue(3'b111, 32'h3333_3333, 32'h4444_4444, 0);

    // Reset mid-DIV discards the operation.
    issue(3'b100, 32'd1, 32'd0, 0);
    issue(3'b101, 32'd2, 32'd0, 0);
    @(negedge clk);
    op_valid = 1'b1; op = 3'b010; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midreset_hilo", {hi_read, lo_read}, 64'd0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", op_ready, 1);
    m_hi = '0; m_lo = '0;
    repeat (W + 4) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      ca = 0;
      if (o <= 3'b011 && $urandom_range(0, 7) == 0)
        ca = $urandom_range(1, o[1] ? W + 1 : ML);
      issue(o, a, b, ca);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
